// File: rtl/axis_segment_trailer.sv
// axis_segment_trailer: passes split AXI-Stream data through and appends a status trailer (count, index, frame end) per segment.
// Define AXIS_SEG_TRAILER_XOR_EN to follow each status beat with a tdata XOR checksum beat.
module axis_segment_trailer #(
    parameter int DSIZE = 32,
    parameter int CNT_W = 16,
    parameter int SEG_W = 12
) (
    input  logic               i_aclk,
    input  logic               i_aresetn,
    input  logic               i_aclken,
    input  logic [DSIZE-1:0]   i_s_tdata,
    input  logic [DSIZE/8-1:0] i_s_tkeep,
    input  logic               i_s_tvalid,
    output logic               o_s_tready,
    input  logic               i_s_tlast,
    input  logic               i_s_tuser,
    output logic [DSIZE-1:0]   o_m_tdata,
    output logic [DSIZE/8-1:0] o_m_tkeep,
    output logic               o_m_tvalid,
    input  logic               i_m_tready,
    output logic               o_m_tlast,
    output logic               o_m_tuser
);
`ifdef AXIS_SEG_TRAILER_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif
    typedef enum logic [1:0] {S_DATA, S_TRAIL, S_XSUM} state_t;
    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_beat_cnt, r_cnt_q, w_cnt_inc;
    logic [SEG_W-1:0]   r_seg_idx, r_idx_q;
    logic               r_end_q;
    logic [DSIZE-1:0]   w_trailer, w_xsum;
    logic               w_is_data, w_acc_in, w_acc_out, w_trl_done;
    assign w_is_data  = r_state == S_DATA;
    assign w_acc_in   = w_is_data && i_s_tvalid && i_m_tready && i_aclken;
    assign w_acc_out  = !w_is_data && i_m_tready && i_aclken;
    assign w_trl_done = w_acc_out && (r_state == (XOR_EN ? S_XSUM : S_TRAIL));
    assign w_cnt_inc  = (&r_beat_cnt) ? r_beat_cnt : r_beat_cnt + CNT_W'(1);
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) r_state <= S_DATA;
        else            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (w_is_data) w_next = (w_acc_in && i_s_tlast) ? S_TRAIL : S_DATA;
        else if (w_acc_out) w_next = (r_state == S_TRAIL && XOR_EN) ? S_XSUM : S_DATA;
    end
    always_comb begin
        w_trailer = '0;
        w_trailer[CNT_W-1:0] = r_cnt_q;
        w_trailer[CNT_W+SEG_W-1:CNT_W] = r_idx_q;
        w_trailer[DSIZE-1] = r_end_q;
    end
    always_comb begin
        o_s_tready = w_is_data && i_m_tready;
        o_m_tvalid = w_is_data ? i_s_tvalid : 1'b1;
        o_m_tdata  = w_is_data ? i_s_tdata : (r_state == S_TRAIL ? w_trailer : w_xsum);
        o_m_tkeep  = w_is_data ? i_s_tkeep : '1;
        o_m_tlast  = !w_is_data && !(XOR_EN && r_state == S_TRAIL);
        o_m_tuser  = !w_is_data && r_end_q;
    end
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_beat_cnt <= '0;
            r_seg_idx  <= '0;
            r_cnt_q    <= '0;
            r_idx_q    <= '0;
            r_end_q    <= 1'b0;
        end else begin
            if (w_acc_in) begin
                r_beat_cnt <= i_s_tlast ? '0 : w_cnt_inc;
                if (i_s_tlast) begin
                    r_cnt_q <= w_cnt_inc;
                    r_idx_q <= r_seg_idx;
                    r_end_q <= i_s_tuser;
                end
            end
            if (w_trl_done) r_seg_idx <= r_end_q ? '0 : r_seg_idx + SEG_W'(1);
        end
    end
`ifdef AXIS_SEG_TRAILER_XOR_EN
    logic [DSIZE-1:0] r_xacc, r_xsum_q;
    assign w_xsum = r_xsum_q;
    // the segment's last beat is folded into the captured checksum
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_xacc   <= '0;
            r_xsum_q <= '0;
        end else if (w_acc_in) begin
            r_xacc <= i_s_tlast ? '0 : r_xacc ^ i_s_tdata;
            if (i_s_tlast) r_xsum_q <= r_xacc ^ i_s_tdata;
        end
    end
`else
    assign w_xsum = '0;
`endif
endmodule

// File: tb/tb_axis_segment_trailer.sv
// tb_axis_segment_trailer: directed checks of pass-through, trailer content, backpressure, wrap, saturation and reset.
module tb_axis_segment_trailer;
`ifdef AXIS_SEG_TRAILER_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, clken = 1'b1;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep = 4'hF;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, m_tready = 1'b1;
    logic        s_tready, m_tvalid, m_tlast, m_tuser;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    int          vec = 0, bad = 0;

    always #5 clk = ~clk;

    axis_segment_trailer #(.DSIZE(32), .CNT_W(4), .SEG_W(2)) dut (
        .i_aclk(clk), .i_aresetn(rst_n), .i_aclken(clken),
        .i_s_tdata(s_tdata), .i_s_tkeep(s_tkeep), .i_s_tvalid(s_tvalid), .o_s_tready(s_tready),
        .i_s_tlast(s_tlast), .i_s_tuser(s_tuser),
        .o_m_tdata(m_tdata), .o_m_tkeep(m_tkeep), .o_m_tvalid(m_tvalid), .i_m_tready(m_tready),
        .o_m_tlast(m_tlast), .o_m_tuser(m_tuser)
    );

    function automatic logic [35:0] obs();
        return {s_tready, m_tvalid, m_tlast, m_tuser, m_tdata};
    endfunction

    // {in tready, out tvalid, tlast, tuser, tdata} expected while a status trailer is presented
    function automatic logic [35:0] exp_trl(input int c, input int i, input bit e);
        logic [31:0] w;
        w = '0;
        w[3:0] = c[3:0];
        w[5:4] = i[1:0];
        w[31] = e;
        return {1'b0, 1'b1, !XOR_EN, e, w};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; m_tready = 1'b1; clken = 1'b1;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic seg(input int n, input bit u, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            s_tdata = base + k; s_tlast = (k == n - 1); s_tuser = u && (k == n - 1); s_tvalid = 1'b1;
            @(negedge clk);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    endtask

    task automatic next_trl();
        @(negedge clk);
        if (XOR_EN) @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        vec++;
        if (obs() !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            bad++; $display("FAIL reset_outputs: got %h want %h", obs(), {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        end
        m_tready = 1'b0; #1;
        vec++;
        if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_tready_follow: got %b want 0", s_tready); end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        s_tkeep = 4'h3;
        for (int k = 0; k < 4; k++) begin
            s_tdata = 32'hA0 + k; s_tlast = (k == 3); s_tvalid = 1'b1;
            #1;
            vec++;
            if ({obs(), m_tkeep} !== {1'b1, 1'b1, 1'b0, 1'b0, 32'hA0 + k, 4'h3}) begin
                bad++; $display("FAIL basic_passthru[%0d]: got %h want %h", k, {obs(), m_tkeep}, {1'b1, 1'b1, 1'b0, 1'b0, 32'hA0 + k, 4'h3});
            end
            @(negedge clk);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; #1;
        vec++;
        if ({obs(), m_tkeep} !== {exp_trl(4, 0, 0), 4'hF}) begin
            bad++; $display("FAIL basic_trailer: got %h want %h", {obs(), m_tkeep}, {exp_trl(4, 0, 0), 4'hF});
        end
        s_tkeep = 4'hF;
        next_trl();
    endtask

    task automatic test_frame();
        int lens [4] = '{3, 3, 1, 2};
        bit ends [4] = '{0, 0, 1, 0};
        int idxs [4] = '{0, 1, 2, 0};
        do_reset();
        for (int s = 0; s < 4; s++) begin
            seg(lens[s], ends[s], 32'h100 * s);
            #1;
            vec++;
            if (obs() !== exp_trl(lens[s], idxs[s], ends[s])) begin
                bad++; $display("FAIL frame_trailer[%0d]: got %h want %h", s, obs(), exp_trl(lens[s], idxs[s], ends[s]));
            end
            next_trl();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        seg(2, 0, 32'h10);
        m_tready = 1'b0; s_tdata = 32'h55; s_tlast = 1'b1; s_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            vec++;
            if (obs() !== exp_trl(2, 0, 0)) begin
                bad++; $display("FAIL bp_hold[%0d]: got %h want %h", c, obs(), exp_trl(2, 0, 0));
            end
            @(negedge clk);
        end
        m_tready = 1'b1; #1;
        vec++;
        if (obs() !== exp_trl(2, 0, 0)) begin
            bad++; $display("FAIL bp_release: got %h want %h", obs(), exp_trl(2, 0, 0));
        end
        next_trl(); #1;
        vec++;
        if (obs() !== {1'b1, 1'b1, 1'b0, 1'b0, 32'h55}) begin
            bad++; $display("FAIL bp_resume: got %h want %h", obs(), {1'b1, 1'b1, 1'b0, 1'b0, 32'h55});
        end
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0; #1;
        vec++;
        if (obs() !== exp_trl(1, 1, 0)) begin
            bad++; $display("FAIL bp_next_trailer: got %h want %h", obs(), exp_trl(1, 1, 0));
        end
        next_trl();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int s = 0; s < 5; s++) begin
            seg(1, 0, 32'h40 + s);
            #1;
            vec++;
            if (obs() !== exp_trl(1, s % 4, 0)) begin
                bad++; $display("FAIL wrap_idx[%0d]: got %h want %h", s, obs(), exp_trl(1, s % 4, 0));
            end
            next_trl();
        end
    endtask

    task automatic test_saturation_reset();
        do_reset();
        seg(20, 0, 32'h100);
        #1;
        vec++;
        if (obs() !== exp_trl(15, 0, 0)) begin
            bad++; $display("FAIL sat_cnt: got %h want %h", obs(), exp_trl(15, 0, 0));
        end
        next_trl();
        seg(3, 0, 32'h200);
        rst_n = 1'b0; #1;
        vec++;
        if (obs() !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h202}) begin
            bad++; $display("FAIL trail_reset: got %h want %h", obs(), {1'b1, 1'b0, 1'b0, 1'b0, 32'h202});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        vec++;
        if (obs() !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h202}) begin
            bad++; $display("FAIL trail_reset_idle: got %h want %h", obs(), {1'b1, 1'b0, 1'b0, 1'b0, 32'h202});
        end
        seg(2, 0, 32'h300);
        #1;
        vec++;
        if (obs() !== exp_trl(2, 0, 0)) begin
            bad++; $display("FAIL reset_idx_clear: got %h want %h", obs(), exp_trl(2, 0, 0));
        end
        next_trl();
    endtask

    task automatic test_clken();
        do_reset();
        clken = 1'b0; s_tdata = 32'h33; s_tlast = 1'b1; s_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vec++;
        if (obs() !== {1'b1, 1'b1, 1'b0, 1'b0, 32'h33}) begin
            bad++; $display("FAIL clken_data_hold: got %h want %h", obs(), {1'b1, 1'b1, 1'b0, 1'b0, 32'h33});
        end
        clken = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0; clken = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        vec++;
        if (obs() !== exp_trl(1, 0, 0)) begin
            bad++; $display("FAIL clken_trailer_hold: got %h want %h", obs(), exp_trl(1, 0, 0));
        end
        clken = 1'b1;
        next_trl(); #1;
        vec++;
        if (obs() !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h33}) begin
            bad++; $display("FAIL clken_release: got %h want %h", obs(), {1'b1, 1'b0, 1'b0, 1'b0, 32'h33});
        end
    endtask

`ifdef AXIS_SEG_TRAILER_XOR_EN
    task automatic test_xor();
        logic [31:0] d [3] = '{32'h1, 32'h2, 32'h4};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            s_tdata = d[k]; s_tlast = (k == 2); s_tvalid = 1'b1;
            @(negedge clk);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; #1;
        vec++;
        if (obs() !== exp_trl(3, 0, 0)) begin
            bad++; $display("FAIL xor_status: got %h want %h", obs(), exp_trl(3, 0, 0));
        end
        @(negedge clk); #1;
        vec++;
        if (obs() !== {1'b0, 1'b1, 1'b1, 1'b0, 32'h7}) begin
            bad++; $display("FAIL xor_sum: got %h want %h", obs(), {1'b0, 1'b1, 1'b1, 1'b0, 32'h7});
        end
        @(negedge clk); #1;
        vec++;
        if (s_tready !== 1'b1) begin bad++; $display("FAIL xor_back_to_data: got %b want 1", s_tready); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_frame();
        test_back_to_back();
        test_wrap();
        test_saturation_reset();
        test_clken();
`ifdef AXIS_SEG_TRAILER_XOR_EN
        test_xor();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
